// File: rtl/ysyx_burst_splitter.sv
// Splits one upstream burst read into back-to-back single-beat memory requests.
// Supports incrementing or critical-word-first wrap ordering and a flush that drains the open beat.
module ysyx_burst_splitter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned WRAP_EN = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up_req,
    output logic              up_ready,
    input  logic [ADDR_W-1:0] up_addr,
    input  logic [LEN_W-1:0]  up_len,
    input  logic              up_flush,
    output logic              up_rvalid,
    output logic [DATA_W-1:0] up_rdata,
    output logic              up_rlast,
    output logic              dn_req_valid,
    output logic [ADDR_W-1:0] dn_addr,
    output logic [1:0]        dn_size,
    input  logic              dn_resp_valid,
    input  logic [DATA_W-1:0] dn_rdata,
    output logic              busy
);

    localparam int unsigned Bytes = DATA_W / 8;
    localparam int unsigned Size  = $clog2(Bytes);

    typedef enum logic [1:0] {StIdle, StBeat, StDrain} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                rvalid_q, rvalid_d;
    logic                rlast_q, rlast_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [LEN_W:0]      beats;
    logic                beats_pow2;
    logic [ADDR_W-1:0]   off;
    logic [ADDR_W-1:0]   inc_addr;
    logic [ADDR_W-1:0]   span_mask;
    logic                last_beat;

    assign beats      = {1'b0, len_q} + (LEN_W + 1)'(1);
    assign beats_pow2 = (beats & (beats - (LEN_W + 1)'(1))) == '0;
    assign off        = ADDR_W'(cnt_q) << Size;
    assign inc_addr   = base_q + off;
    assign span_mask  = (ADDR_W'(beats) << Size) - ADDR_W'(1);
    assign last_beat  = cnt_q == len_q;

    // Wrap keeps the aligned block fixed and rotates the offset within it.
    assign dn_addr = ((WRAP_EN != 0) && beats_pow2) ?
                     ((base_q & ~span_mask) | (inc_addr & span_mask)) : inc_addr;

    assign dn_size      = 2'(Size);
    assign dn_req_valid = state_q != StIdle;
    assign up_ready     = state_q == StIdle;
    assign busy         = state_q != StIdle;
    assign up_rvalid    = rvalid_q;
    assign up_rlast     = rlast_q;
    assign up_rdata     = rdata_q;

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        rvalid_d = 1'b0;
        rlast_d  = 1'b0;
        rdata_d  = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (up_req && !up_flush) begin
                    base_d  = up_addr;
                    len_d   = up_len;
                    cnt_d   = '0;
                    state_d = StBeat;
                end
            end
            StBeat: begin
                if (up_flush) begin
                    // A beat completing in the flush cycle is dropped, not forwarded.
                    if (dn_resp_valid) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        state_d = StDrain;
                    end
                end else if (dn_resp_valid) begin
                    rvalid_d = 1'b1;
                    rdata_d  = dn_rdata;
                    rlast_d  = last_beat;
                    if (last_beat) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            StDrain: begin
                if (dn_resp_valid) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            base_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: tb/tb_ysyx_burst_splitter.sv
// Bench for ysyx_burst_splitter: three instances (32-bit incr, 64-bit incr, 32-bit wrap)
// driven one at a time and checked against an address/beat reference model.
module tb_ysyx_burst_splitter;

    logic        clk = 1'b0;
    logic        rst;
    logic        up_req, up_flush, resp;
    logic [31:0] up_addr;
    logic [7:0]  up_len;
    logic [63:0] rdata_in;
    logic [1:0]  sel;

    logic [2:0]  ready, rvalid, rlast, dnv, busy;
    logic [31:0] dn_addr [3];
    logic [1:0]  dn_size [3];
    logic [31:0] rd0, rd2;
    logic [63:0] rd1;

    logic        obs_ready, obs_rvalid, obs_rlast, obs_dnv, obs_busy;
    logic [31:0] obs_dn_addr;
    logic [1:0]  obs_dn_size;
    logic [63:0] obs_rdata;

    int checks = 0;
    int failures = 0;
    int fixed_lat[$];

    always #5 clk = ~clk;

    ysyx_burst_splitter #(.DATA_W(32), .WRAP_EN(0)) u_inc32 (
        .clk(clk), .rst(rst), .up_req(up_req && sel == 2'd0), .up_ready(ready[0]),
        .up_addr(up_addr), .up_len(up_len), .up_flush(up_flush), .up_rvalid(rvalid[0]),
        .up_rdata(rd0), .up_rlast(rlast[0]), .dn_req_valid(dnv[0]), .dn_addr(dn_addr[0]),
        .dn_size(dn_size[0]), .dn_resp_valid(resp && sel == 2'd0), .dn_rdata(rdata_in[31:0]),
        .busy(busy[0])
    );

    ysyx_burst_splitter #(.DATA_W(64), .WRAP_EN(0)) u_inc64 (
        .clk(clk), .rst(rst), .up_req(up_req && sel == 2'd1), .up_ready(ready[1]),
        .up_addr(up_addr), .up_len(up_len), .up_flush(up_flush), .up_rvalid(rvalid[1]),
        .up_rdata(rd1), .up_rlast(rlast[1]), .dn_req_valid(dnv[1]), .dn_addr(dn_addr[1]),
        .dn_size(dn_size[1]), .dn_resp_valid(resp && sel == 2'd1), .dn_rdata(rdata_in),
        .busy(busy[1])
    );

    ysyx_burst_splitter #(.DATA_W(32), .WRAP_EN(1)) u_wrap32 (
        .clk(clk), .rst(rst), .up_req(up_req && sel == 2'd2), .up_ready(ready[2]),
        .up_addr(up_addr), .up_len(up_len), .up_flush(up_flush), .up_rvalid(rvalid[2]),
        .up_rdata(rd2), .up_rlast(rlast[2]), .dn_req_valid(dnv[2]), .dn_addr(dn_addr[2]),
        .dn_size(dn_size[2]), .dn_resp_valid(resp && sel == 2'd2), .dn_rdata(rdata_in[31:0]),
        .busy(busy[2])
    );

    always_comb begin
        obs_ready   = ready[sel];
        obs_rvalid  = rvalid[sel];
        obs_rlast   = rlast[sel];
        obs_dnv     = dnv[sel];
        obs_busy    = busy[sel];
        obs_dn_addr = dn_addr[sel];
        obs_dn_size = dn_size[sel];
        case (sel)
            2'd1:    obs_rdata = rd1;
            2'd2:    obs_rdata = {32'h0, rd2};
            default: obs_rdata = {32'h0, rd0};
        endcase
    end

    function automatic int beat_bytes(input int k);
        return (k == 1) ? 8 : 4;
    endfunction

    function automatic logic [63:0] dmask(input int k);
        return (k == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    // Wrap: stay inside the aligned (len+1)*B block, rotating from the start offset.
    function automatic logic [31:0] ref_addr(input int k, input logic [31:0] base,
                                             input int len, input int i);
        longint unsigned b    = longint'(beat_bytes(k));
        longint unsigned span = longint'(len + 1) * b;
        longint unsigned bl   = {32'h0, base};
        longint unsigned a;
        if (k == 2 && (((len + 1) & len) == 0))
            a = (bl - (bl % span)) + (((bl % span) + longint'(i) * b) % span);
        else
            a = bl + longint'(i) * b;
        return a[31:0];
    endfunction

    // Runs one burst on instance k starting at a negedge; flush_kind 1 = flush while waiting
    // (then a second, ignored flush in drain), 2 = flush on the response cycle.
    task automatic run_burst(input int k, input logic [31:0] base, input int len,
                             input int maxlat, input int flush_beat, input int flush_kind);
        logic [63:0] d, prev_d;
        logic [31:0] ea;
        int          lat;
        bit          prev_rv, ev;
        sel = 2'(k);
        #1;
        checks++;
        if (obs_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_ready k=%0d: got %b want 1", k, obs_ready);
        end
        up_addr = base;
        up_len  = 8'(len);
        up_req  = 1'b1;
        @(negedge clk);
        up_req  = 1'b0;
        prev_rv = 1'b0;
        prev_d  = '0;
        for (int i = 0; i <= len; i++) begin
            ea  = ref_addr(k, base, len, i);
            d   = {$urandom, $urandom} & dmask(k);
            lat = (i < fixed_lat.size()) ? fixed_lat[i] : int'($urandom_range(0, maxlat));
            if (i == flush_beat && flush_kind == 1) lat = 3;
            for (int w = 0; w <= lat; w++) begin
                ev = (w == 0) && prev_rv;
                checks += 4;
                if (obs_dnv !== 1'b1) begin
                    failures++;
                    $display("FAIL dn_req_valid k=%0d beat=%0d w=%0d: got %b want 1", k, i, w, obs_dnv);
                end
                if (obs_busy !== 1'b1) begin
                    failures++;
                    $display("FAIL busy k=%0d beat=%0d w=%0d: got %b want 1", k, i, w, obs_busy);
                end
                if (obs_dn_addr !== ea) begin
                    failures++;
                    $display("FAIL dn_addr k=%0d beat=%0d w=%0d: got %h want %h", k, i, w, obs_dn_addr, ea);
                end
                if (obs_rvalid !== ev) begin
                    failures++;
                    $display("FAIL up_rvalid k=%0d beat=%0d w=%0d: got %b want %b", k, i, w, obs_rvalid, ev);
                end
                if (ev) begin
                    checks += 2;
                    if (obs_rdata !== prev_d) begin
                        failures++;
                        $display("FAIL up_rdata k=%0d beat=%0d: got %h want %h", k, i - 1, obs_rdata, prev_d);
                    end
                    if (obs_rlast !== 1'b0) begin
                        failures++;
                        $display("FAIL up_rlast_early k=%0d beat=%0d: got %b want 0", k, i - 1, obs_rlast);
                    end
                end
                if (i == flush_beat && flush_kind == 1 && w < 2) up_flush = 1'b1;
                if (w == lat) begin
                    resp     = 1'b1;
                    rdata_in = d;
                    if (i == flush_beat && flush_kind == 2) up_flush = 1'b1;
                end
                @(negedge clk);
                resp     = 1'b0;
                up_flush = 1'b0;
                rdata_in = {$urandom, $urandom};
            end
            if (i == flush_beat) begin
                checks += 3;
                if (obs_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL flush_idle k=%0d: got ready=%b want 1", k, obs_ready);
                end
                if (obs_dnv !== 1'b0) begin
                    failures++;
                    $display("FAIL flush_dnv k=%0d: got %b want 0", k, obs_dnv);
                end
                if (obs_rvalid !== 1'b0) begin
                    failures++;
                    $display("FAIL flush_rvalid k=%0d: got %b want 0", k, obs_rvalid);
                end
                return;
            end
            prev_rv = 1'b1;
            prev_d  = d;
        end
        checks += 6;
        if (obs_rvalid !== 1'b1) begin
            failures++;
            $display("FAIL last_rvalid k=%0d: got %b want 1", k, obs_rvalid);
        end
        if (obs_rdata !== prev_d) begin
            failures++;
            $display("FAIL last_rdata k=%0d: got %h want %h", k, obs_rdata, prev_d);
        end
        if (obs_rlast !== 1'b1) begin
            failures++;
            $display("FAIL last_rlast k=%0d: got %b want 1", k, obs_rlast);
        end
        if (obs_ready !== 1'b1) begin
            failures++;
            $display("FAIL last_ready k=%0d: got %b want 1", k, obs_ready);
        end
        if (obs_busy !== 1'b0) begin
            failures++;
            $display("FAIL last_busy k=%0d: got %b want 0", k, obs_busy);
        end
        if (obs_dnv !== 1'b0) begin
            failures++;
            $display("FAIL last_dnv k=%0d: got %b want 0", k, obs_dnv);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int k = 0; k < 3; k++) begin
            sel = 2'(k);
            #1;
            checks++;
            if (obs_ready !== 1'b1 || obs_busy !== 1'b0 || obs_rvalid !== 1'b0 ||
                obs_rlast !== 1'b0 || obs_rdata !== 64'h0 || obs_dnv !== 1'b0 ||
                obs_dn_addr !== 32'h0) begin
                failures++;
                $display("FAIL %s k=%0d: got rdy=%b busy=%b rv=%b rl=%b rd=%h dnv=%b addr=%h want 1 0 0 0 0 0 0",
                         tag, k, obs_ready, obs_busy, obs_rvalid, obs_rlast, obs_rdata, obs_dnv,
                         obs_dn_addr);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        for (int k = 0; k < 3; k++) begin
            sel = 2'(k);
            #1;
            checks++;
            if (obs_dn_size !== ((k == 1) ? 2'd3 : 2'd2)) begin
                failures++;
                $display("FAIL dn_size k=%0d: got %0d want %0d", k, obs_dn_size, (k == 1) ? 3 : 2);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_idle_ignore();
        sel      = 2'd0;
        up_addr  = 32'h1000;
        up_len   = 8'd1;
        up_req   = 1'b1;
        up_flush = 1'b1;
        @(negedge clk);
        up_req   = 1'b0;
        up_flush = 1'b0;
        checks += 2;
        if (obs_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_flush_blocks_req: got ready=%b want 1", obs_ready);
        end
        if (obs_dnv !== 1'b0) begin
            failures++;
            $display("FAIL idle_flush_dnv: got %b want 0", obs_dnv);
        end
        resp = 1'b1;
        @(negedge clk);
        resp = 1'b0;
        checks += 2;
        if (obs_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL idle_stray_resp_rvalid: got %b want 0", obs_rvalid);
        end
        if (obs_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_stray_resp_ready: got %b want 1", obs_ready);
        end
    endtask

    task automatic test_basic();
        fixed_lat = '{0, 0, 0, 0};
        run_burst(0, 32'h3000_0010, 3, 0, -1, 0);
        fixed_lat.delete();
    endtask

    task automatic test_wrap();
        fixed_lat = '{0, 1, 0, 2};
        run_burst(2, 32'h8000_0018, 3, 0, -1, 0);
        run_burst(2, 32'h8000_0018, 2, 0, -1, 0);
        fixed_lat.delete();
        run_burst(2, 32'h4000_0024, 7, 2, -1, 0);
    endtask

    task automatic test_latency();
        fixed_lat = '{0, 3, 1, 7};
        run_burst(0, 32'h3000_0100, 3, 0, -1, 0);
        fixed_lat.delete();
    endtask

    task automatic test_flush_wait();
        fixed_lat = '{0};
        run_burst(0, 32'h2000_0040, 3, 0, 1, 1);
        fixed_lat.delete();
        run_burst(0, 32'h2000_0080, 1, 1, -1, 0);
    endtask

    task automatic test_flush_resp_and_single();
        fixed_lat = '{0, 0, 0};
        run_burst(0, 32'h2000_0200, 3, 0, 2, 2);
        fixed_lat.delete();
        run_burst(0, 32'h2000_0300, 0, 2, -1, 0);
    endtask

    task automatic test_reset_mid_burst();
        sel     = 2'd0;
        up_addr = 32'h5000_0000;
        up_len  = 8'd3;
        up_req  = 1'b1;
        @(negedge clk);
        up_req = 1'b0;
        resp   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        resp = 1'b0;
        rst  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset_mid_burst");
        sel  = 2'd0;
        resp = 1'b1;
        @(negedge clk);
        resp = 1'b0;
        check_reset_outputs("stale_resp_after_reset");
    endtask

    task automatic test_wide();
        run_burst(1, 32'h0000_0FF8, 1, 1, -1, 0);
    endtask

    task automatic test_back_to_back_random();
        int k, len, fb, kind;
        logic [31:0] base;
        for (int n = 0; n < 30; n++) begin
            k    = int'($urandom_range(0, 2));
            len  = ($urandom_range(0, 4) == 0) ? 15 : int'($urandom_range(0, 9));
            base = $urandom & ~32'(beat_bytes(k) - 1);
            fb   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
            kind = int'($urandom_range(1, 2));
            run_burst(k, base, len, 3, fb, kind);
        end
    endtask

    initial begin
        rst      = 1'b1;
        up_req   = 1'b0;
        up_flush = 1'b0;
        resp     = 1'b0;
        up_addr  = '0;
        up_len   = '0;
        rdata_in = '0;
        sel      = 2'd0;
        @(negedge clk);
        test_reset();
        test_idle_ignore();
        test_basic();
        test_wrap();
        test_latency();
        test_flush_wait();
        test_flush_resp_and_single();
        test_reset_mid_burst();
        test_wide();
        test_back_to_back_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_burst_splitter.md
Name: ysyx_burst_splitter

Overview:
Parametrised bridge that turns one upstream burst read (I-Cache line refill or any multi-beat reader) into a sequence of single-beat requests on the simple request/response memory port of the D-stage SoC. It generalises the fixed 4-beat IFU refill path with:
- any burst length up to 2^LEN_W beats;
- configurable data width;
- optional critical-word-first wrap ordering;
- a flush/abort path that drains the in-flight beat safely.
It sits between a cache's refill port and the SoC IFU/LSU request port.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, beat data width in bits (8/16/32/64; power of two)
LEN_W, 8, width of burst length field (beats-1 encoding)
WRAP_EN, 0, 1 = wrap addressing for power-of-two bursts; 0 = always incrementing

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
up_req  in  1  burst request; sampled only when up_ready=1
up_ready  out  1  splitter idle, may accept burst
up_addr  in  ADDR_W  burst start address (DATA_W/8 aligned)
up_len  in  LEN_W  beats minus one
up_flush  in  1  abort current burst
up_rvalid  out  1  one beat of read data valid
up_rdata  out  DATA_W  beat data
up_rlast  out  1  final beat of burst, qualified by up_rvalid
dn_req_valid  out  1  single-beat request valid, held until response
dn_addr  out  ADDR_W  single-beat address
dn_size  out  2  log2(DATA_W/8), constant
dn_resp_valid  in  1  one-cycle response strobe
dn_rdata  in  DATA_W  response data
busy  out  1  state != IDLE

Behaviour:
- Reset state:
  - IDLE; up_ready=1; busy=0; up_rvalid=0, up_rlast=0, up_rdata=0; dn_req_valid=0, dn_addr=0.
  - Internal beat counter and base/len registers = 0.
  - Reset mid-burst returns to IDLE on the next edge; a later dn_resp_valid is ignored.
- States:
  - IDLE: accept when up_req && !up_flush. Latch base=up_addr, len=up_len, cnt=0; go to BEAT.
  - BEAT: dn_req_valid=1; dn_addr and dn_size are stable for the whole wait.
  - DRAIN: dn_req_valid=1 with the same address. Wait for dn_resp_valid, discard the data, then go to IDLE.
- Latency:
  - up_req accepted at cycle T gives dn_req_valid=1 at T+1.
  - A beat completes in the cycle where dn_req_valid && dn_resp_valid (cycle R).
  - up_rvalid/up_rdata are registered and appear at R+1.
  - Next beat's dn_req_valid and dn_addr update at R+1, so there is no idle cycle between beats.
  - A response in the same cycle dn_req_valid first rises is legal.
- Beat bookkeeping:
  - On completion with cnt<len: cnt++, stay in BEAT.
  - On completion with cnt==len: up_rlast=1 at R+1, state goes to IDLE at R+1 (up_ready=1 at R+1), cnt clears.
  - len=0 is a legal 1-beat burst: up_rvalid and up_rlast both at R+1.
- Address arithmetic, with B = DATA_W/8 and off = cnt*B:
  - Incrementing: dn_addr = base + off, modulo 2^ADDR_W.
  - Wrap mode applies when WRAP_EN=1 and len+1 is a power of two. Mask m = (len+1)*B - 1; dn_addr = (base & ~m) | ((base + off) & m).
  - Wrap mode with non-power-of-two len+1: incrementing.
- Flush:
  - IDLE: flush ignored; a same-cycle up_req is not accepted.
  - BEAT with no response that cycle: go to DRAIN.
  - BEAT with a response that cycle: that beat is discarded (no up_rvalid) and state goes to IDLE.
  - DRAIN: a further flush is ignored.
  - Flush does not retract an up_rvalid already registered for the current cycle.
  - No up_rvalid is produced for any beat after the flush cycle.
- Upstream handshake:
  - up_req when up_ready=0 is ignored; the requester holds it.
  - dn_resp_valid while dn_req_valid=0 is ignored; no state change.
- busy mirrors !up_ready.

Test Plan:
1. Basic 4-beat burst: up_addr=0x3000_0010, up_len=3, immediate responses D0..D3 → dn_addr 0x…10, 0x…14, 0x…18, 0x…1C on consecutive cycles; 4 up_rvalid pulses with data D0..D3; up_rlast only on the 4th; up_ready=1 the cycle after the last response.
2. Wrap mode (WRAP_EN=1), 4-beat burst: up_addr=0x8000_0018, up_len=3 → dn_addr 0x18, 0x1C, 0x10, 0x14 (upper bits 0x8000_00); non-power-of-two up_len=2 from 0x18 → 0x18, 0x1C, 0x20.
3. Variable response latency: responses after 0, 3, 1, 7 idle cycles → dn_addr stable while waiting; each up_rvalid exactly one cycle after its response; no duplicate beats.
4. Flush while waiting: flush during beat 1 with no response → DRAIN with dn_addr unchanged; response arrives 2 cycles later and is discarded; IDLE next cycle; zero further up_rvalid; a new burst is accepted immediately after.
5. Flush on the response cycle, plus single-beat burst: flush coincides with beat 2's response → no up_rvalid for it, IDLE next cycle. A 1-beat burst (up_len=0) → single up_rvalid with up_rlast=1.
6. Reset mid-burst, plus 64-bit data width: rst during beat 2 → all outputs back to reset values on the next edge; a stale dn_resp_valid is ignored. With DATA_W=64, a 2-beat burst from 0x0FF8 → addresses 0x0FF8, 0x1000 and dn_size=3.
